uart_frame_parser: RTL and testbench
====================================

// Module: uart_frame_parser
// PURPOSE
// - Sits directly downstream of the UART receiver: consumes its byte stream (rx data + 1-cycle ready strobe).
// - Delimits frames of the form SOF(0x5A), LEN, PAYLOAD[LEN], CSUM.
// - Buffers the payload, validates length and checksum, enforces an inter-byte timeout.
// - Replays only good payloads on a valid/ready stream for the command layer.
// PARAMETERS
// - SOF_BYTE     8'h5A  start-of-frame marker
// - MAX_LEN      16     max payload bytes (1..255); sets buffer depth
// - TIMEOUT_CYC  8680   idle i_clk cycles allowed between bytes inside a frame (~4 byte times at 25 MHz / 115200)
// PORTS
// - i_clk          in   1  system clock (25 MHz)
// - i_rst_n        in   1  synchronous, active-low reset
// - i_rx_dat       in   8  byte from UART receiver
// - i_rx_rdy       in   1  1-cycle strobe: i_rx_dat valid
// - o_pl_dat       out  8  payload byte
// - o_pl_valid     out  1  o_pl_dat valid
// - i_pl_ready     in   1  consumer accepts byte when valid & ready
// - o_pl_last      out  1  marks final payload byte; qualified by o_pl_valid
// - o_frame_ok     out  1  1-cycle pulse: frame passed checksum
// - o_err_csum     out  1  1-cycle pulse: checksum mismatch, frame dropped
// - o_err_len      out  1  1-cycle pulse: LEN==0 or LEN>MAX_LEN, frame dropped
// - o_err_timeout  out  1  1-cycle pulse: inter-byte timeout, frame dropped
// - o_err_busy     out  1  1-cycle pulse: byte arrived while replaying, byte discarded
// BEHAVIOUR
// - Reset (i_rst_n=0 at posedge): state IDLE. All outputs 0. Counters and checksum cleared. Buffer contents don't care.
//   Reset mid-frame or mid-replay abandons everything with no error pulse.
// - A "byte event" is i_rx_rdy=1 at a posedge.
// - States:
//   - IDLE: byte==SOF_BYTE -> LEN; any other byte ignored, no error.
//   - LEN: store len, csum=byte. len==0 or len>MAX_LEN -> o_err_len, IDLE. Else -> PAYLOAD with idx=0.
//   - PAYLOAD: buf[idx]=byte, csum+=byte (mod 256), idx++. On idx reaching len -> CSUM.
//   - CSUM: byte==csum -> o_frame_ok, OUT. Mismatch -> o_err_csum, IDLE.
//   - OUT: replay buf[0..len-1]; after the last handshake -> IDLE.
// - Checksum: 8-bit wrapping sum of LEN and all payload bytes; SOF is excluded.
// - Timeout: counter runs only in LEN/PAYLOAD/CSUM; cleared on every byte event and on state entry.
//   Reaching TIMEOUT_CYC cycles without a byte -> o_err_timeout, IDLE.
//   Byte event in the same cycle as expiry: the byte wins and the counter clears.
// - Latency: CSUM byte event at cycle N -> o_frame_ok=1 at N+1; o_pl_valid=1 with buf[0] at N+2.
// - Stream rules:
//   - o_pl_dat/o_pl_last are held stable while valid & !ready.
//   - With ready held high, one byte transfers per cycle with no bubbles.
//   - o_pl_valid deasserts the cycle after the last handshake.
// - Byte events in OUT: discarded, o_err_busy pulse; replay unaffected.
//   SOF is not recognised until IDLE is re-entered.
// - At most one status pulse per cycle; error pulses never coincide with o_frame_ok.
// TESTING
// - Good frame: bytes 5A 03 11 22 33 69, ready=1 -> frame_ok pulse; stream 11,22,33 on consecutive cycles, last on 33.
// - Bad checksum: 5A 02 AA BB 00 -> o_err_csum pulse; o_pl_valid stays 0; next good frame parses normally.
// - Length errors: 5A 00 -> o_err_len. 5A 11 with MAX_LEN=16 -> o_err_len. Leading junk 00 FF before 5A is ignored.
// - Timeout: 5A 02 11, then silence for TIMEOUT_CYC cycles -> o_err_timeout, state IDLE.
//   Subsequent 22 69 produces no output.
// - Backpressure/busy: good 4-byte frame with ready toggling 1,0,0,1 -> data held stable across stalls, no loss.
//   A byte strobed mid-replay -> o_err_busy pulse, output sequence intact.
// - Reset mid-PAYLOAD (i_rst_n=0 one cycle) -> all outputs 0; next full frame 5A 01 7F 80 -> stream 7F, last=1.

Source files
------------

// File: rtl/uart_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_frame_parser
//   Sits behind a UART receiver and turns its byte stream into validated
//   payloads. A frame is SOF, LEN, PAYLOAD[LEN], CSUM. The checksum is the
//   8-bit wrapping sum of LEN and the payload bytes. The payload is buffered.
//   Only frames that pass the length and checksum checks, and that arrive
//   without an inter-byte timeout, are replayed on a valid/ready stream.
//
// Ports
//   i_clk          system clock
//   i_rst_n        synchronous, active-low reset
//   i_rx_dat[7:0]  byte from the UART receiver
//   i_rx_rdy       1-cycle strobe, i_rx_dat valid
//   o_pl_dat[7:0]  replayed payload byte
//   o_pl_valid     o_pl_dat valid
//   i_pl_ready     consumer accepts the byte when valid & ready
//   o_pl_last      final payload byte, qualified by o_pl_valid
//   o_frame_ok     1-cycle pulse, frame accepted
//   o_err_csum     1-cycle pulse, checksum mismatch, frame dropped
//   o_err_len      1-cycle pulse, LEN == 0 or LEN > MAX_LEN, frame dropped
//   o_err_timeout  1-cycle pulse, inter-byte silence too long, frame dropped
//   o_err_busy     1-cycle pulse, byte arrived during replay and was discarded
// -----------------------------------------------------------------------------
module uart_frame_parser #(
  parameter logic [7:0] SOF_BYTE    = 8'h5A,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 8680
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_dat,
  input  logic       i_rx_rdy,
  output logic [7:0] o_pl_dat,
  output logic       o_pl_valid,
  input  logic       i_pl_ready,
  output logic       o_pl_last,
  output logic       o_frame_ok,
  output logic       o_err_csum,
  output logic       o_err_len,
  output logic       o_err_timeout,
  output logic       o_err_busy
);

  localparam int            IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int            TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLIM    = TW'(TIMEOUT_CYC - 1);
  localparam logic [8:0]    LEN_MAX = 9'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_OUT
  } state_t;

  state_t        state;
  logic [7:0]    len;
  logic [7:0]    idx;
  logic [7:0]    csum;
  logic [TW-1:0] tcnt;
  logic [7:0]    buf_mem [MAX_LEN];

  logic          in_frame;
  logic          tmo;
  logic [7:0]    idx_inc;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  always_comb begin
    in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
    // The timeout fires on the TIMEOUT_CYC-th idle cycle. A byte landing on
    // that same cycle suppresses it.
    tmo      = in_frame && !i_rx_rdy && (tcnt == TLIM);
    idx_inc  = idx + 8'd1;
  end

  // Payload buffer. Only the control path is reset.
  always_ff @(posedge i_clk) begin
    if (state == S_PAYLOAD && i_rx_rdy) begin
      buf_mem[idx[IW-1:0]] <= i_rx_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      len           <= '0;
      idx           <= '0;
      csum          <= '0;
      tcnt          <= '0;
      o_pl_dat      <= '0;
      o_pl_valid    <= 1'b0;
      o_pl_last     <= 1'b0;
      o_frame_ok    <= 1'b0;
      o_err_csum    <= 1'b0;
      o_err_len     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_err_busy    <= 1'b0;
    end else begin
      o_frame_ok    <= 1'b0;
      o_err_csum    <= 1'b0;
      o_err_len     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_err_busy    <= 1'b0;

      // The counter idles at zero outside a frame. Every frame state is
      // entered on a byte event, so it also starts from zero on entry.
      tcnt <= (in_frame && !i_rx_rdy && !tmo) ? tcnt + 1'b1 : '0;

      case (state)
        S_IDLE: begin
          if (i_rx_rdy && i_rx_dat == SOF_BYTE) begin
            state <= S_LEN;
          end
        end

        S_LEN: begin
          if (i_rx_rdy) begin
            len  <= i_rx_dat;
            csum <= i_rx_dat;
            if (i_rx_dat == 8'd0 || {1'b0, i_rx_dat} > LEN_MAX) begin
              o_err_len <= 1'b1;
              state     <= S_IDLE;
            end else begin
              idx   <= '0;
              state <= S_PAYLOAD;
            end
          end else if (tmo) begin
            o_err_timeout <= 1'b1;
            state         <= S_IDLE;
          end
        end

        S_PAYLOAD: begin
          if (i_rx_rdy) begin
            csum <= csum_add(csum, i_rx_dat);
            idx  <= idx_inc;
            if (idx_inc == len) begin
              state <= S_CSUM;
            end
          end else if (tmo) begin
            o_err_timeout <= 1'b1;
            state         <= S_IDLE;
          end
        end

        S_CSUM: begin
          if (i_rx_rdy) begin
            if (i_rx_dat == csum) begin
              o_frame_ok <= 1'b1;
              idx        <= '0;
              state      <= S_OUT;
            end else begin
              o_err_csum <= 1'b1;
              state      <= S_IDLE;
            end
          end else if (tmo) begin
            o_err_timeout <= 1'b1;
            state         <= S_IDLE;
          end
        end

        S_OUT: begin
          // Bytes arriving during replay are flagged and dropped. The replay
          // is not disturbed.
          if (i_rx_rdy) begin
            o_err_busy <= 1'b1;
          end
          // valid low inside OUT means the first byte has not been loaded
          // yet. After that, a new byte is loaded on each handshake so there
          // are no bubbles.
          if (!o_pl_valid) begin
            o_pl_valid <= 1'b1;
            o_pl_dat   <= buf_mem[idx[IW-1:0]];
            o_pl_last  <= (idx_inc == len);
            idx        <= idx_inc;
          end else if (i_pl_ready) begin
            if (o_pl_last) begin
              o_pl_valid <= 1'b0;
              o_pl_last  <= 1'b0;
              state      <= S_IDLE;
            end else begin
              o_pl_dat  <= buf_mem[idx[IW-1:0]];
              o_pl_last <= (idx_inc == len);
              idx       <= idx_inc;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_parser
//   Directed and randomized frames driven into uart_frame_parser. Each frame's
//   expected status events and payload stream are derived from its byte list:
//   the length rule, the wrapping sum and the timeout rule. They are compared
//   with what a monitor records from the DUT.
// -----------------------------------------------------------------------------
module tb_uart_frame_parser;

  localparam int T       = 200;
  localparam int MAX_LEN = 16;

  localparam int EV_OK   = 1;
  localparam int EV_CSUM = 2;
  localparam int EV_LEN  = 3;
  localparam int EV_TMO  = 4;
  localparam int EV_BUSY = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_dat = '0;
  logic       rx_rdy = 1'b0;
  logic [7:0] pl_dat;
  logic       pl_valid;
  logic       pl_ready = 1'b1;
  logic       pl_last;
  logic       frame_ok, err_csum, err_len, err_timeout, err_busy;

  int n_chk = 0;
  int n_err = 0;

  int         exp_ev[$];
  int         got_ev[$];
  logic [8:0] exp_dat[$];
  logic [8:0] got_dat[$];

  logic [7:0] sb[$];
  int         sg[$];

  int   rdy_mode = 0;
  int   pidx = 0;
  logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  logic       stall_prev = 1'b0;
  logic [7:0] dat_prev = '0;
  logic       last_prev = 1'b0;
  int         npulse;

  uart_frame_parser #(
    .SOF_BYTE(8'h5A),
    .MAX_LEN(MAX_LEN),
    .TIMEOUT_CYC(T)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_rx_dat(rx_dat),
    .i_rx_rdy(rx_rdy),
    .o_pl_dat(pl_dat),
    .o_pl_valid(pl_valid),
    .i_pl_ready(pl_ready),
    .o_pl_last(pl_last),
    .o_frame_ok(frame_ok),
    .o_err_csum(err_csum),
    .o_err_len(err_len),
    .o_err_timeout(err_timeout),
    .o_err_busy(err_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Consumer ready: constant high, random, or the fixed 1,0,0,1 pattern.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: pl_ready = 1'b1;
      1: pl_ready = 1'($urandom_range(0, 1));
      default: begin
        pl_ready = pat[pidx];
        pidx = (pidx + 1) % 4;
      end
    endcase
  end

  // Monitor, sampled on the falling edge.
  always @(negedge clk) begin
    npulse = int'(frame_ok) + int'(err_csum) + int'(err_len) + int'(err_timeout) + int'(err_busy);
    if (npulse != 0) begin
      check("one_pulse", npulse, 1);
      if (frame_ok)    got_ev.push_back(EV_OK);
      if (err_csum)    got_ev.push_back(EV_CSUM);
      if (err_len)     got_ev.push_back(EV_LEN);
      if (err_timeout) got_ev.push_back(EV_TMO);
      if (err_busy)    got_ev.push_back(EV_BUSY);
    end
    if (stall_prev) begin
      check("stall_hold", {pl_valid, pl_last, pl_dat}, {1'b1, last_prev, dat_prev});
    end
    if (pl_valid && pl_ready) got_dat.push_back({pl_last, pl_dat});
    stall_prev = rst_n && pl_valid && !pl_ready;
    dat_prev   = pl_dat;
    last_prev  = pl_last;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic byte_ev(input logic [7:0] b);
    rx_dat = b;
    rx_rdy = 1'b1;
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
  endtask

  task automatic send_all();
    for (int i = 0; i < sb.size(); i++) begin
      idle(sg[i]);
      byte_ev(sb[i]);
    end
    sb.delete();
    sg.delete();
  endtask

  task automatic push(input logic [7:0] b, input int g);
    sb.push_back(b);
    sg.push_back(g);
  endtask

  // Wait for the expected traffic, bounded, then compare and clear.
  task automatic settle(input string tag);
    int waited = 0;
    while ((got_dat.size() < exp_dat.size() || got_ev.size() < exp_ev.size()) && waited < 3000) begin
      idle(1);
      waited++;
    end
    idle(4);
    check({tag, "_ev_n"}, got_ev.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size(); i++)
      check({tag, "_ev"}, (i < got_ev.size()) ? got_ev[i] : -1, exp_ev[i]);
    check({tag, "_dat_n"}, got_dat.size(), exp_dat.size());
    for (int i = 0; i < exp_dat.size(); i++)
      check({tag, "_dat"}, (i < got_dat.size()) ? {23'd0, got_dat[i]} : 32'hFFFF, {23'd0, exp_dat[i]});
    check({tag, "_idle_vld"}, pl_valid, 1'b0);
    exp_ev.delete();
    got_ev.delete();
    exp_dat.delete();
    got_dat.delete();
  endtask

  function automatic int gap_in();
    return ($urandom_range(0, 9) == 0) ? T - 1 : $urandom_range(0, 4);
  endfunction

  function automatic logic [7:0] non_sof();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'h5A) b = 8'h00;
    return b;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         kind, len, keep, nj;
    logic [7:0] cs, b;
    logic [7:0] body[$];

    idle(3);
    check("reset_outs", {pl_valid, pl_last, pl_dat, frame_ok, err_csum, err_len, err_timeout, err_busy}, '0);
    rst_n = 1'b1;
    idle(2);

    // Good frame with latency and stream checks.
    exp_ev.push_back(EV_OK);
    exp_dat.push_back({1'b0, 8'h11});
    exp_dat.push_back({1'b0, 8'h22});
    exp_dat.push_back({1'b1, 8'h33});
    byte_ev(8'h5A); byte_ev(8'h03); byte_ev(8'h11); byte_ev(8'h22); byte_ev(8'h33);
    byte_ev(8'h69);
    check("ok_lat", frame_ok, 1'b1);
    check("vld_lat", pl_valid, 1'b0);
    idle(1);
    check("s0", {pl_valid, pl_last, pl_dat}, {1'b1, 1'b0, 8'h11});
    idle(1);
    check("s1", {pl_valid, pl_last, pl_dat}, {1'b1, 1'b0, 8'h22});
    idle(1);
    check("s2", {pl_valid, pl_last, pl_dat}, {1'b1, 1'b1, 8'h33});
    idle(1);
    check("s_end", pl_valid, 1'b0);
    settle("good");

    // Bad checksum, then a good frame.
    exp_ev.push_back(EV_CSUM);
    exp_ev.push_back(EV_OK);
    exp_dat.push_back({1'b0, 8'h11});
    exp_dat.push_back({1'b0, 8'h22});
    exp_dat.push_back({1'b1, 8'h33});
    byte_ev(8'h5A); byte_ev(8'h02); byte_ev(8'hAA); byte_ev(8'hBB); byte_ev(8'h00);
    byte_ev(8'h5A); byte_ev(8'h03); byte_ev(8'h11); byte_ev(8'h22); byte_ev(8'h33);
    byte_ev(8'h69);
    settle("badcs");

    // Length errors, with leading junk.
    exp_ev.push_back(EV_LEN);
    exp_ev.push_back(EV_LEN);
    byte_ev(8'h00); byte_ev(8'hFF); byte_ev(8'h5A); byte_ev(8'h00);
    byte_ev(8'h5A); byte_ev(8'h11);
    settle("len");

    // Timeout followed by ignored bytes.
    exp_ev.push_back(EV_TMO);
    byte_ev(8'h5A); byte_ev(8'h02); byte_ev(8'h11);
    idle(T);
    byte_ev(8'h22); byte_ev(8'h69);
    settle("tmo");

    // Gap of T-1 idle cycles: the byte lands on the expiry cycle and wins.
    exp_ev.push_back(EV_OK);
    exp_dat.push_back({1'b1, 8'h42});
    byte_ev(8'h5A); byte_ev(8'h01);
    idle(T - 1); byte_ev(8'h42);
    idle(T - 1); byte_ev(8'h43);
    settle("tmo_edge");

    // Backpressure with ready pattern 1,0,0,1.
    rdy_mode = 2;
    exp_ev.push_back(EV_OK);
    exp_dat.push_back({1'b0, 8'hA1});
    exp_dat.push_back({1'b0, 8'hB2});
    exp_dat.push_back({1'b0, 8'hC3});
    exp_dat.push_back({1'b1, 8'hD4});
    byte_ev(8'h5A); byte_ev(8'h04); byte_ev(8'hA1); byte_ev(8'hB2); byte_ev(8'hC3);
    byte_ev(8'hD4); byte_ev(8'hEE);
    settle("bp");
    rdy_mode = 0;

    // Byte strobed mid-replay.
    exp_ev.push_back(EV_OK);
    exp_ev.push_back(EV_BUSY);
    exp_dat.push_back({1'b0, 8'h01});
    exp_dat.push_back({1'b0, 8'h02});
    exp_dat.push_back({1'b0, 8'h03});
    exp_dat.push_back({1'b1, 8'h04});
    byte_ev(8'h5A); byte_ev(8'h04); byte_ev(8'h01); byte_ev(8'h02); byte_ev(8'h03);
    byte_ev(8'h04); byte_ev(8'h0E); byte_ev(8'h5A);
    settle("busy");

    // Reset mid-payload, then a fresh frame.
    byte_ev(8'h5A); byte_ev(8'h03); byte_ev(8'h11);
    rst_n = 1'b0;
    idle(1);
    check("rst_mid_outs", {pl_valid, pl_last, pl_dat, frame_ok, err_csum, err_len, err_timeout, err_busy}, '0);
    rst_n = 1'b1;
    exp_ev.push_back(EV_OK);
    exp_dat.push_back({1'b1, 8'h7F});
    byte_ev(8'h5A); byte_ev(8'h01); byte_ev(8'h7F); byte_ev(8'h80);
    settle("rst_mid");

    // Randomized frames.
    rdy_mode = 1;
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 4);
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) push(non_sof(), $urandom_range(0, 3));
      push(8'h5A, $urandom_range(0, 3));
      if (kind == 3) len = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAX_LEN + 1, 255);
      else           len = $urandom_range(1, MAX_LEN);
      body.delete();
      body.push_back(8'(len));
      cs = 8'(len);
      for (int i = 0; i < len && kind != 3; i++) begin
        b = 8'($urandom);
        body.push_back(b);
        cs = 8'(cs + b);
        if (kind <= 1) exp_dat.push_back({(i == len - 1), b});
      end
      if (kind == 2) cs = cs ^ 8'($urandom_range(1, 255));
      body.push_back(cs);
      case (kind)
        0, 1: begin
          foreach (body[i]) push(body[i], gap_in());
          exp_ev.push_back(EV_OK);
          if ($urandom_range(0, 2) == 0) begin
            push(8'($urandom), $urandom_range(0, 1));
            exp_ev.push_back(EV_BUSY);
          end
          send_all();
        end
        2: begin
          foreach (body[i]) push(body[i], gap_in());
          exp_ev.push_back(EV_CSUM);
          send_all();
        end
        3: begin
          push(body[0], gap_in());
          exp_ev.push_back(EV_LEN);
          send_all();
        end
        default: begin
          keep = $urandom_range(0, len + 1);
          for (int i = 0; i < keep; i++) push(body[i], gap_in());
          exp_ev.push_back(EV_TMO);
          send_all();
          idle(T);
          push(non_sof(), $urandom_range(0, 3));
          push(non_sof(), $urandom_range(0, 3));
          send_all();
        end
      endcase
      settle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
